// File: rtl/nn_entry_ctrl.sv
// nn_entry_ctrl: keypad feature entry, classifier launch and result hold sequencer
module nn_entry_ctrl #(
    parameter int FEAT_W     = 4,
    parameter int CLASS_W    = 4,
    parameter int NN_LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_valid,
    input  logic [1:0]         key_cmd,
    input  logic [FEAT_W-1:0]  key_data,
    output logic               key_ready,
    output logic [FEAT_W-1:0]  sl,
    output logic [FEAT_W-1:0]  sw,
    output logic [FEAT_W-1:0]  pl,
    output logic [FEAT_W-1:0]  pw,
    output logic [1:0]         field,
    output logic               nn_start,
    input  logic [CLASS_W-1:0] nn_species,
    output logic [CLASS_W-1:0] species,
    output logic               result_valid,
    output logic               busy
);
    typedef enum logic [1:0] {ENTRY, FULL, RUN, DONE} state_t;
    localparam logic [1:0] CMD_DIGIT = 2'd0;
    localparam logic [1:0] CMD_BS    = 2'd1;
    localparam logic [1:0] CMD_CLR   = 2'd2;
    localparam logic [1:0] CMD_ENT   = 2'd3;
    state_t             state_q, state_d;
    logic [FEAT_W-1:0]  feat_q [4];
    logic [FEAT_W-1:0]  feat_d [4];
    logic [1:0]         field_q, field_d;
    logic [CLASS_W-1:0] species_q, species_d;
    logic               rv_q, rv_d;
    logic               nn_start_q, nn_start_d;
    logic               busy_q, busy_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               acc;
    logic               launch;
    assign key_ready    = (state_q != RUN);
    assign acc          = key_valid && key_ready;
    assign sl           = feat_q[0];
    assign sw           = feat_q[1];
    assign pl           = feat_q[2];
    assign pw           = feat_q[3];
    assign field        = field_q;
    assign nn_start     = nn_start_q;
    assign species      = species_q;
    assign result_valid = rv_q;
    assign busy         = busy_q;
    // Next-state logic: key handling per state, run countdown and result capture
    always_comb begin
        state_d    = state_q;
        feat_d     = feat_q;
        field_d    = field_q;
        species_d  = species_q;
        rv_d       = rv_q;
        nn_start_d = 1'b0;
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        launch     = 1'b0;
        if (acc && key_cmd == CMD_CLR) begin
            for (int i = 0; i < 4; i++) feat_d[i] = '0;
            field_d = 2'd0;
            rv_d    = 1'b0;
            state_d = ENTRY;
        end else begin
            case (state_q)
                ENTRY: begin
                    if (acc && key_cmd == CMD_DIGIT) begin
                        feat_d[field_q] = key_data;
                        field_d         = field_q + 2'd1;
                        state_d         = (field_q == 2'd3) ? FULL : ENTRY;
                    end else if (acc && key_cmd == CMD_BS && field_q != 2'd0) begin
                        feat_d[field_q - 2'd1] = '0;
                        field_d                = field_q - 2'd1;
                    end
                end
                FULL: begin
                    if (acc && key_cmd == CMD_BS) begin
                        feat_d[3] = '0;
                        field_d   = 2'd3;
                        state_d   = ENTRY;
                    end else if (acc && key_cmd == CMD_ENT) begin
                        launch = 1'b1;
                    end
                end
                RUN: begin
                    if (cnt_q == 8'd1) begin
                        species_d = nn_species;
                        rv_d      = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = DONE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    if (acc && key_cmd == CMD_DIGIT) begin
                        rv_d    = 1'b0;
                        feat_d  = '{key_data, '0, '0, '0};
                        field_d = 2'd1;
                        state_d = ENTRY;
                    end else if (acc && key_cmd == CMD_ENT) begin
                        launch = 1'b1;
                    end
                end
            endcase
        end
        if (launch) begin
            rv_d       = 1'b0;
            nn_start_d = 1'b1;
            busy_d     = 1'b1;
            cnt_d      = 8'(NN_LATENCY);
            state_d    = RUN;
        end
    end
    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ENTRY;
            for (int i = 0; i < 4; i++) feat_q[i] <= '0;
            field_q    <= 2'd0;
            species_q  <= '0;
            rv_q       <= 1'b0;
            nn_start_q <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            feat_q     <= feat_d;
            field_q    <= field_d;
            species_q  <= species_d;
            rv_q       <= rv_d;
            nn_start_q <= nn_start_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_nn_entry_ctrl.sv
// tb_nn_entry_ctrl: directed self-checking bench for nn_entry_ctrl
module tb_nn_entry_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [1:0] key_cmd = 2'd0;
    logic [3:0] key_data = 4'd0;
    logic       key_ready;
    logic [3:0] sl, sw, pl, pw;
    logic [1:0] field;
    logic       nn_start;
    logic [3:0] nn_species = 4'd2;
    logic [3:0] species;
    logic       result_valid;
    logic       busy;
    int checks = 0;
    int errors = 0;

    nn_entry_ctrl #(.FEAT_W(4), .CLASS_W(4), .NN_LATENCY(4)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_cmd(key_cmd),
        .key_data(key_data), .key_ready(key_ready), .sl(sl), .sw(sw), .pl(pl),
        .pw(pw), .field(field), .nn_start(nn_start), .nn_species(nn_species),
        .species(species), .result_valid(result_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic key(input logic [1:0] c, input logic [3:0] d);
        @(negedge clk);
        key_valid = 1'b1;
        key_cmd   = c;
        key_data  = d;
    endtask

    task automatic idle();
        @(negedge clk);
        key_valid = 1'b0;
        key_cmd   = 2'd0;
        key_data  = 4'd0;
    endtask

    task automatic feats(input string tag, input logic [3:0] a, b, c, d, input logic [1:0] f);
        chk({tag, ".sl"}, 32'(sl), 32'(a));
        chk({tag, ".sw"}, 32'(sw), 32'(b));
        chk({tag, ".pl"}, 32'(pl), 32'(c));
        chk({tag, ".pw"}, 32'(pw), 32'(d));
        chk({tag, ".field"}, 32'(field), 32'(f));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        feats("rst", 0, 0, 0, 0, 0);
        chk("rst.species", 32'(species), 0);
        chk("rst.rv", 32'(result_valid), 0);
        chk("rst.nn_start", 32'(nn_start), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.key_ready", 32'(key_ready), 1);
        rst_n = 1'b1;

        key(0, 5); key(0, 3); key(0, 1); key(0, 2); idle();
        feats("fill", 5, 3, 1, 2, 0);
        chk("fill.key_ready", 32'(key_ready), 1);
        key(0, 9); idle();
        feats("full_digit_ignored", 5, 3, 1, 2, 0);

        key(1, 0); idle();
        feats("full_bs", 5, 3, 1, 0, 3);
        key(0, 4); idle();
        feats("refill", 5, 3, 1, 4, 0);

        key(3, 0);
        key(0, 7);
        chk("run1.nn_start", 32'(nn_start), 1);
        chk("run1.busy", 32'(busy), 1);
        chk("run1.key_ready", 32'(key_ready), 0);
        @(negedge clk);
        chk("run2.nn_start", 32'(nn_start), 0);
        chk("run2.busy", 32'(busy), 1);
        repeat (2) @(negedge clk);
        chk("run4.busy", 32'(busy), 1);
        chk("run4.rv", 32'(result_valid), 0);
        idle();
        chk("done.busy", 32'(busy), 0);
        chk("done.rv", 32'(result_valid), 1);
        chk("done.species", 32'(species), 2);
        chk("done.key_ready", 32'(key_ready), 1);
        feats("done_frozen", 5, 3, 1, 4, 0);
        key(1, 0); idle();
        chk("done_bs.rv", 32'(result_valid), 1);
        feats("done_bs", 5, 3, 1, 4, 0);

        nn_species = 4'd1;
        key(3, 0); idle();
        chk("rerun.nn_start", 32'(nn_start), 1);
        chk("rerun.rv", 32'(result_valid), 0);
        chk("rerun.species_kept", 32'(species), 2);
        repeat (3) @(negedge clk);
        chk("rerun3.rv", 32'(result_valid), 0);
        @(negedge clk);
        chk("rerun.rv", 32'(result_valid), 1);
        chk("rerun.species", 32'(species), 1);
        chk("rerun.busy", 32'(busy), 0);

        key(0, 6); idle();
        chk("done_digit.rv", 32'(result_valid), 0);
        chk("done_digit.species", 32'(species), 1);
        feats("done_digit", 6, 0, 0, 0, 1);
        key(3, 0); idle();
        chk("entry_enter.nn_start", 32'(nn_start), 0);
        chk("entry_enter.busy", 32'(busy), 0);

        key(2, 0); idle();
        feats("clear", 0, 0, 0, 0, 0);
        key(0, 7); key(0, 9); idle();
        feats("digits79", 7, 9, 0, 0, 2);
        key(1, 0); key(1, 0); key(1, 0); idle();
        feats("bs3", 0, 0, 0, 0, 0);

        key(0, 5); key(0, 3); key(0, 1); key(0, 2);
        key(3, 0); idle();
        chk("rst_run.nn_start", 32'(nn_start), 1);
        @(negedge clk);
        chk("rst_run.busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        feats("rst_run", 0, 0, 0, 0, 0);
        chk("rst_run.busy", 32'(busy), 0);
        chk("rst_run.species", 32'(species), 0);
        chk("rst_run.rv", 32'(result_valid), 0);
        chk("rst_run.key_ready", 32'(key_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst.rv", 32'(result_valid), 0);
        chk("post_rst.busy", 32'(busy), 0);
        chk("post_rst.key_ready", 32'(key_ready), 1);
        key(0, 8); idle();
        feats("post_rst_entry", 8, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nn_entry_ctrl.md
# nn_entry_ctrl

Sequencing controller between the keypad decoder and the classifier network. Collects the four 4-bit iris features (sepal length, sepal width, petal length, petal width) one key event at a time, supports backspace, clear and enter, then launches the classifier, waits its fixed latency and holds the latched species for the display driver. It replaces the free-running keypad-to-network connection with an explicit entry/run/result sequence.

## Interface
- FEAT_W, 4, width of each feature value
- CLASS_W, 4, width of species code
- NN_LATENCY, 4, cycles from nn_start to valid nn_species; legal 1..255
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle key event strobe
- key_cmd  in  2  00 digit, 01 backspace, 10 clear, 11 enter
- key_data  in  FEAT_W  digit value, used only when key_cmd=00
- key_ready  out  1  high when a key event is accepted this cycle
- sl, sw, pl, pw  out  FEAT_W each  registered feature values to the network
- field  out  2  index of next feature to be written (0=sl..3=pw)
- nn_start  out  1  one-cycle launch pulse to the network
- nn_species  in  CLASS_W  network result
- species  out  CLASS_W  latched result for display
- result_valid  out  1  species holds a result for current features
- busy  out  1  high while waiting on the network

## Operation
- States: ENTRY, FULL, RUN, DONE. Reset state ENTRY.
- Reset values: sl=sw=pl=pw=0, field=0, species=0, result_valid=0, nn_start=0, busy=0, key_ready=1.
- key_ready = (state != RUN), combinational from state. Events with key_ready low are dropped, never queued.
- ENTRY: digit → feature[field]<=key_data, field+1; writing field 3 → FULL (field wraps to 0). Backspace → if field>0, field-1 and feature[field-1]<=0; ignored at field 0. Clear → all features 0, field 0. Enter ignored.
- FULL: digit ignored. Backspace → pw<=0, field=3, ENTRY. Clear → all features 0, field 0, ENTRY. Enter → nn_start<=1, counter<=NN_LATENCY, RUN.
- RUN: busy=1; features frozen; counter decrements each cycle; at edge where counter==1: species<=nn_species, result_valid<=1, DONE.
- DONE: species and result_valid held. Digit → result_valid<=0, sl<=key_data, sw=pl=pw=0, field=1, ENTRY. Clear → result_valid<=0, features 0, field 0, ENTRY. Enter → result_valid<=0, nn_start pulse, RUN (rerun same features). Backspace ignored.
- species keeps last value after result_valid drops; only result_valid qualifies it.
- Counter 8 bits; NN_LATENCY=1 gives capture on the edge after the nn_start edge.

## Timing
- Key event sampled on rising edge with key_valid=1 and key_ready=1; feature/field update visible next cycle.
- nn_start high exactly one cycle, the cycle after the accepting enter edge; busy rises same cycle.
- species/result_valid update on the NN_LATENCY-th rising edge after the edge that raised nn_start; busy falls same edge.
- Features stable from nn_start rise through DONE exit.
- rst_n assertion at any time (including mid-RUN) forces reset values immediately; no result latched, pending run abandoned. Deassertion takes effect at next clk edge.
- Back-to-back key events on consecutive cycles all accepted while state permits.

## Test plan
- Reset, digits 5,3,1,2 on consecutive cycles → sl=5 sw=3 pl=1 pw=2, field=0, state FULL, key_ready=1.
- From FULL, enter with NN_LATENCY=4, nn_species driven 2 → nn_start one cycle, busy 4 cycles, species=2 and result_valid=1 on 4th edge; key events during busy ignored.
- Digits 7,9, backspace, backspace, backspace → sl=0 sw=0, field=0; third backspace no effect.
- In DONE, digit 6 → result_valid=0, sl=6, sw=pl=pw=0, field=1; enter in ENTRY ignored (no nn_start).
- In DONE, enter → rerun, result_valid low until new capture; nn_species change to 1 yields species=1.
- rst_n low two cycles into RUN → all outputs reset values, no later result_valid, state ENTRY after release.
